// File: rtl/if_id_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_id_stage : fetch-to-decode 2-entry skid buffer with opcode decode.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module if_id_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pcin,
  input  logic [XLEN-1:0] instin,
  input  logic            out_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] pcout,
  output logic [XLEN-1:0] instout,
  output logic [2:0]      imgsel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  localparam logic [2:0] c_IMM_I    = 3'b000;
  localparam logic [2:0] c_IMM_S    = 3'b001;
  localparam logic [2:0] c_IMM_B    = 3'b010;
  localparam logic [2:0] c_IMM_U    = 3'b011;
  localparam logic [2:0] c_IMM_J    = 3'b100;
  localparam logic [2:0] c_IMM_NONE = 3'b111;

  logic            r_out_valid;
  logic            r_skid_valid;
  logic            r_in_ready;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_inst;

  logic            w_accept;
  logic            w_advance;
  logic            w_out_valid_nxt;
  logic            w_skid_valid_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_skid_pc_nxt;
  logic [XLEN-1:0] w_skid_inst_nxt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_advance = ~r_out_valid | out_ready;

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_inst_nxt  = r_skid_inst;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_advance) begin
      if (r_skid_valid) begin
        w_out_valid_nxt = 1'b1;
        w_pc_nxt        = r_skid_pc;
        w_inst_nxt      = r_skid_inst;
        if (w_accept) begin
          w_skid_pc_nxt   = pcin;
          w_skid_inst_nxt = instin;
        end else begin
          w_skid_valid_nxt = 1'b0;
        end
      end else if (w_accept) begin
        w_out_valid_nxt = 1'b1;
        w_pc_nxt        = pcin;
        w_inst_nxt      = instin;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_pc_nxt    = pcin;
      w_skid_inst_nxt  = instin;
    end
  end

  // in_ready is registered from the next skid state so it costs no input-side logic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_pc         <= '0;
      r_inst       <= NOP_INST;
      r_skid_pc    <= '0;
      r_skid_inst  <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_inst  <= w_skid_inst_nxt;
    end
  end

  always_comb begin
    imgsel  = c_IMM_NONE;
    illegal = 1'b0;
    case (r_inst[6:0])
      c_OPC_LOAD, c_OPC_OPIMM, c_OPC_JALR: imgsel = c_IMM_I;
      c_OPC_STORE:                         imgsel = c_IMM_S;
      c_OPC_BRANCH:                        imgsel = c_IMM_B;
      c_OPC_LUI, c_OPC_AUIPC:              imgsel = c_IMM_U;
      c_OPC_JAL:                           imgsel = c_IMM_J;
      c_OPC_OP:                            imgsel = c_IMM_NONE;
      default:                             illegal = 1'b1;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign pcout     = r_pc;
  assign instout   = r_inst;
  assign rs1       = r_inst[19:15];
  assign rs2       = r_inst[24:20];
  assign rd        = r_inst[11:7];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_id_stage : scoreboard bench with directed fetch vectors.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_if_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  imgsel;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pcin;
  logic [31:0] instin;
  logic        out_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] pcout;
  logic [31:0] instout;
  logic [2:0]  imgsel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  if_id_stage #(.XLEN(32), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .pcin(pcin), .instin(instin), .out_ready(out_ready), .flush(flush),
    .out_valid(out_valid), .pcout(pcout), .instout(instout), .imgsel(imgsel),
    .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every consumed output is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        a = '{pc: pcout, inst: instout, imgsel: imgsel, illegal: illegal,
              rs1: rs1, rs2: rs2, rd: rd};
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: actual pc=%h inst=%h required=none", pcout, instout);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL out_entry: actual pc=%h inst=%h imgsel=%b ill=%b rs1=%0d rs2=%0d rd=%0d required pc=%h inst=%h imgsel=%b ill=%b rs1=%0d rs2=%0d rd=%0d",
                     a.pc, a.inst, a.imgsel, a.illegal, a.rs1, a.rs2, a.rd,
                     e.pc, e.inst, e.imgsel, e.illegal, e.rs1, e.rs2, e.rd);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] sel,
                      input logic ill, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                      input logic [4:0] e_rd);
    logic ok;
    int   n;
    in_valid = 1'b1;
    pcin     = pc;
    instin   = inst;
    n        = 0;
    ok       = 1'b0;
    while (!ok && n < 50) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (ok) begin
      sb_q.push_back('{pc: pc, inst: inst, imgsel: sel, illegal: ill,
                       rs1: e_rs1, rs2: e_rs2, rd: e_rd});
    end else begin
      total++;
      bad++;
      $display("FAIL push_timeout: actual in_ready=0 required=1 pc=%h", pc);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      cycles(1);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; pcin = '0; instin = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset
    cycles(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_instout", 64'(instout), 64'h13);
    check("rst_pcout", 64'(pcout), 64'd0);
    rstn = 1'b1;
    cycles(1);
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Streaming with out_ready high
    out_ready = 1'b1;
    push(32'h0, 32'h0050_0093, 3'b000, 1'b0, 5'd0, 5'd5, 5'd1);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_pcout", 64'(pcout), 64'h0);
    push(32'h4, 32'h0020_8133, 3'b111, 1'b0, 5'd1, 5'd2, 5'd2);
    push(32'h8, 32'hFE00_0EE3, 3'b010, 1'b0, 5'd0, 5'd0, 5'd29);
    in_valid = 1'b0;
    wait_drain();
    cycles(1);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: word0 in output, word1 in skid, word2 held off
    out_ready = 1'b0;
    push(32'h10, 32'h0050_0093, 3'b000, 1'b0, 5'd0, 5'd5, 5'd1);
    push(32'h14, 32'h0011_2023, 3'b001, 1'b0, 5'd2, 5'd1, 5'd0);
    in_valid = 1'b1; pcin = 32'h18; instin = 32'h0000_10B7;
    cycles(2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_pc", 64'(pcout), 64'h10);
    out_ready = 1'b1;
    push(32'h18, 32'h0000_10B7, 3'b011, 1'b0, 5'd0, 5'd0, 5'd1);
    in_valid = 1'b0;
    wait_drain();

    // Flush with a full buffer; pc 0x40 must never appear
    out_ready = 1'b0;
    push(32'h20, 32'h0080_006F, 3'b100, 1'b0, 5'd0, 5'd8, 5'd0);
    push(32'h24, 32'h0000_000B, 3'b111, 1'b1, 5'd0, 5'd0, 5'd0);
    in_valid = 1'b1; pcin = 32'h40; instin = 32'h0050_0093; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cycles(4);

    // Decode sweep
    push(32'h100, 32'h0000_10B7, 3'b011, 1'b0, 5'd0, 5'd0, 5'd1);
    push(32'h104, 32'h0080_006F, 3'b100, 1'b0, 5'd0, 5'd8, 5'd0);
    push(32'h108, 32'h0011_2023, 3'b001, 1'b0, 5'd2, 5'd1, 5'd0);
    push(32'h10C, 32'h0000_000B, 3'b111, 1'b1, 5'd0, 5'd0, 5'd0);
    push(32'h110, 32'h0050_0090, 3'b111, 1'b1, 5'd0, 5'd5, 5'd1);
    push(32'h114, 32'h0050_0097, 3'b011, 1'b0, 5'd0, 5'd5, 5'd1);
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-operation with a full, stalled buffer
    out_ready = 1'b0;
    push(32'h200, 32'h0020_8133, 3'b111, 1'b0, 5'd1, 5'd2, 5'd2);
    push(32'h204, 32'hFE00_0EE3, 3'b010, 1'b0, 5'd0, 5'd0, 5'd29);
    in_valid = 1'b0;
    rstn = 1'b0;
    cycles(1);
    sb_q.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_instout", 64'(instout), 64'h13);
    check("mid_rst_pcout", 64'(pcout), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rstn = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    cycles(3);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
